// File: rtl/ov5640_cfg_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ov5640_cfg_seq
// Walks the OV5640 register-write table after power-up and issues one I2C
// write per {addr16,data8} entry through a byte-wide I2C master. A transfer
// that never completes is recovered by pulsing the master reset and retrying.
// The video pipeline holds off capture until cfg_done is set.
//
// Ports
//   sys_clk, sys_rst_n  system clock / asynchronous active-low reset
//   cfg_restart         pulse; reruns the table from entry 0 (DONE/ERR only)
//   i2c_clk             master drive clock (sys_clk-synchronous)
//   i2c_end             master transfer-complete, one i2c_clk period wide
//   cfg_data            table entry at cfg_idx: [23:8] reg addr, [7:0] value
//   cfg_idx             table index
//   i2c_start           transfer request to the master
//   wr_en/rd_en/addr_num constant write / no read / 16-bit address
//   byte_addr, wr_data  latched register address and value
//   i2c_rst_n           active-low master reset (ANDed with sys_rst_n above)
//   busy                high while not in DONE/ERR
//   cfg_done, cfg_err   level flags: table written / entry failed
// ---------------------------------------------------------------------------
module ov5640_cfg_seq #(
    parameter int               IDX_W       = 8,
    parameter logic [IDX_W-1:0] REG_NUM     = IDX_W'(250),
    parameter logic [19:0]      PWR_DLY_CYC = 20'd1000000,
    parameter logic [15:0]      GAP_CYC     = 16'd500,
    parameter logic [19:0]      TIMEOUT_CYC = 20'd200000,
    parameter int               MAX_RETRY   = 3,
    parameter int               RST_CYC     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_restart,
    input  logic             i2c_clk,
    input  logic             i2c_end,
    input  logic [23:0]      cfg_data,
    output logic [IDX_W-1:0] cfg_idx,
    output logic             i2c_start,
    output logic             wr_en,
    output logic             rd_en,
    output logic             addr_num,
    output logic [15:0]      byte_addr,
    output logic [7:0]       wr_data,
    output logic             i2c_rst_n,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Terminal values of the single shared phase counter.
    localparam logic [19:0]        PWR_LAST  = PWR_DLY_CYC - 20'd1;
    localparam logic [19:0]        GAP_LAST  = {4'd0, GAP_CYC} - 20'd1;
    localparam logic [19:0]        TMO_LAST  = TIMEOUT_CYC - 20'd1;
    localparam logic [19:0]        RST_LAST  = 20'(RST_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_LOAD,
        S_START,
        S_BUSY,
        S_RECOVER,
        S_GAP,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q,     state_d;
    logic [19:0]        cnt_q,       cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [15:0]        addr_q,      addr_d;
    logic [7:0]         data_q,      data_d;
    logic               start_q,     start_d;
    logic               i2c_rst_n_q, i2c_rst_n_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;
    logic               busy_q,      busy_d;
    logic               clk_dly_q;
    logic               end_dly_q;

    logic               clk_rise;
    logic               end_rise;

    // Both sources are sys_clk-synchronous, so a single delay flop suffices
    // for edge detection without a synchroniser.
    assign clk_rise = i2c_clk & ~clk_dly_q;
    assign end_rise = i2c_end & ~end_dly_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        start_d     = start_q;
        i2c_rst_n_d = i2c_rst_n_q;
        done_d      = done_q;
        err_d       = err_q;
        busy_d      = busy_q;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_LOAD: begin
                addr_d  = cfg_data[23:8];
                data_d  = cfg_data[7:0];
                start_d = 1'b1;
                cnt_d   = '0;          // timeout counter starts clean
                state_d = S_START;
            end

            S_START: begin
                // Request is held until the master samples it on an i2c_clk rise.
                if (clk_rise) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                // A completion in the same cycle as the timeout still counts.
                if (end_rise) begin
                    idx_d   = idx_q + IDX_W'(1);
                    retry_d = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        retry_d     = retry_q + RETRY_W'(1);
                        i2c_rst_n_d = 1'b0;
                        state_d     = S_RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_RECOVER: begin
                // Master held in reset; cfg_idx is untouched so the same entry
                // is reissued after the gap.
                if (cnt_q == RST_LAST) begin
                    cnt_d       = '0;
                    i2c_rst_n_d = 1'b1;
                    state_d     = S_GAP;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == REG_NUM) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_DONE, S_ERR: begin
                // Restart skips the power wait: the sensor is already powered.
                if (cfg_restart) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end

            default: state_d = S_PWR_WAIT;
        endcase
    end

    // NOTE: every flop here is a small control register, so all of them take
    // the asynchronous reset; there is no storage array that would need to be
    // left out of the reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            retry_q     <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            i2c_rst_n_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            clk_dly_q   <= 1'b0;
            end_dly_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            start_q     <= start_d;
            i2c_rst_n_q <= i2c_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            clk_dly_q   <= i2c_clk;
            end_dly_q   <= i2c_end;
        end
    end

    assign cfg_idx   = idx_q;
    assign i2c_start = start_q;
    assign byte_addr = addr_q;
    assign wr_data   = data_q;
    assign i2c_rst_n = i2c_rst_n_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign wr_en     = 1'b1;
    assign rd_en     = 1'b0;
    assign addr_num  = 1'b1;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ov5640_cfg_seq
// Drives ov5640_cfg_seq with a behavioural I2C master model and a three-entry
// table. Expected writes are queued from a list-level reference model and
// popped by the master model each time it accepts a request.
// ---------------------------------------------------------------------------
module tb_ov5640_cfg_seq;

    localparam int N       = 3;
    localparam int PWR     = 100;
    localparam int GAP     = 10;
    localparam int TMO     = 2000;
    localparam int RETRIES = 1;
    localparam int RSTLEN  = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cfg_restart;
    logic        i2c_clk;
    logic        i2c_end;
    logic [23:0] cfg_data;
    logic [7:0]  cfg_idx;
    logic        i2c_start;
    logic        wr_en;
    logic        rd_en;
    logic        addr_num;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;
    logic        i2c_rst_n;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;

    logic [23:0] tbl [N];
    assign cfg_data = (cfg_idx < 8'(N)) ? tbl[cfg_idx[1:0]] : 24'h0;

    ov5640_cfg_seq #(
        .IDX_W      (8),
        .REG_NUM    (8'd3),
        .PWR_DLY_CYC(20'd100),
        .GAP_CYC    (16'd10),
        .TIMEOUT_CYC(20'd2000),
        .MAX_RETRY  (1),
        .RST_CYC    (16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_restart(cfg_restart),
        .i2c_clk    (i2c_clk),
        .i2c_end    (i2c_end),
        .cfg_data   (cfg_data),
        .cfg_idx    (cfg_idx),
        .i2c_start  (i2c_start),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr_num   (addr_num),
        .byte_addr  (byte_addr),
        .wr_data    (wr_data),
        .i2c_rst_n  (i2c_rst_n),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [23:0] exp_q [$];
    bit          exp_done;
    bit          exp_err;
    int          exp_idx;

    bit          hang_once_en = 1'b0;
    bit          hang_all_en  = 1'b0;
    logic [15:0] hang_once_addr = '0;
    logic [15:0] hang_all_addr  = '0;

    int n_acc        = 0;
    int acc_cyc      = 0;
    int last_end_cyc = 0;
    int n_pulse      = 0;

    task automatic randomize_table();
        for (int i = 0; i < N; i++)
            tbl[i] = {4'(i + 1), 12'($urandom), 8'($urandom)};
    endtask

    // Expected write list: each entry once; an entry that hangs once is written
    // twice; an entry that always hangs is written RETRIES+1 times and the run
    // ends in error at that index.
    task automatic ref_build(input int once_i, input int all_i);
        hang_once_en = (once_i >= 0);
        hang_all_en  = (all_i >= 0);
        if (once_i >= 0) hang_once_addr = tbl[once_i][23:8];
        if (all_i  >= 0) hang_all_addr  = tbl[all_i][23:8];
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_idx  = N;
        for (int i = 0; i < N; i++) begin
            int tries;
            tries = (i == all_i) ? RETRIES + 1 : (i == once_i) ? 2 : 1;
            repeat (tries) exp_q.push_back(tbl[i]);
            if (i == all_i) begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                exp_idx  = i;
                break;
            end
        end
    endtask

    // ---------------- I2C master model + monitor ----------------
    // i2c_clk toggles every 4 sys_clk cycles; a request is taken on an i2c_clk
    // rise, finishes 2..5 i2c_clk periods later with a one-period i2c_end.
    initial begin : master
        int  div;
        int  rem;
        int  low_len;
        bit  m_busy;
        bit  m_hang;
        bit  start_prev;
        bit  taken_prev;
        bit  raised;
        div = 0; rem = 0; low_len = 0;
        m_busy = 0; m_hang = 0; start_prev = 0; taken_prev = 0;
        i2c_clk = 1'b0;
        i2c_end = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && start_prev) begin
                if (taken_prev) check_eq("start_drop_after_rise", i2c_start, 0);
                else            check_eq("start_held", i2c_start, 1);
            end
            if (sys_rst_n && !i2c_rst_n) begin
                if (low_len == 0) check_eq("timeout_cycles", cyc - acc_cyc, TMO);
                low_len++;
            end else if (low_len > 0) begin
                check_eq("rst_pulse_len", low_len, RSTLEN);
                low_len = 0;
                n_pulse++;
            end
            start_prev = i2c_start;
            taken_prev = 1'b0;
            raised     = 1'b0;
            div++;
            if (div == 4) begin
                div     = 0;
                i2c_clk = ~i2c_clk;
                raised  = i2c_clk;
            end
            if (!sys_rst_n || !i2c_rst_n) begin
                m_busy     = 1'b0;
                m_hang     = 1'b0;
                i2c_end    = 1'b0;
                start_prev = 1'b0;
            end else if (raised) begin
                if (i2c_end) i2c_end = 1'b0;
                if (i2c_start) begin
                    check_eq("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        logic [23:0] e;
                        e = exp_q.pop_front();
                        check_eq("write_entry", {byte_addr, wr_data}, e);
                    end
                    n_acc++;
                    acc_cyc    = cyc + 1;
                    taken_prev = 1'b1;
                    m_busy     = 1'b1;
                    rem        = $urandom_range(2, 5);
                    m_hang     = (hang_all_en && byte_addr == hang_all_addr) ||
                                 (hang_once_en && byte_addr == hang_once_addr);
                    if (hang_once_en && byte_addr == hang_once_addr) hang_once_en = 1'b0;
                end else if (m_busy && !m_hang) begin
                    rem--;
                    if (rem == 0) begin
                        m_busy       = 1'b0;
                        i2c_end      = 1'b1;
                        last_end_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- main sequence helpers ----------------
    int done_cyc = 0;

    task automatic check_reset(input string tag);
        check_eq({tag, "_cfg_idx"},   cfg_idx,   0);
        check_eq({tag, "_byte_addr"}, byte_addr, 0);
        check_eq({tag, "_wr_data"},   wr_data,   0);
        check_eq({tag, "_i2c_start"}, i2c_start, 0);
        check_eq({tag, "_i2c_rst_n"}, i2c_rst_n, 1);
        check_eq({tag, "_cfg_done"},  cfg_done,  0);
        check_eq({tag, "_cfg_err"},   cfg_err,   0);
        check_eq({tag, "_busy"},      busy,      1);
    endtask

    // Counts sys_clk edges until i2c_start is seen high (sampled 1 ns after edge).
    task automatic measure_start(input string name, input int exp);
        int n;
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!i2c_start && n < 1000);
        check_eq(name, n, exp);
    endtask

    task automatic wait_finish();
        for (int i = 0; i < 20000 && !(cfg_done || cfg_err); i++) begin
            @(posedge sys_clk);
            #1;
        end
        done_cyc = cyc;
        check_eq("finish_seen", cfg_done | cfg_err, 1);
    endtask

    task automatic check_outcome(input string tag);
        check_eq({tag, "_cfg_done"}, cfg_done, exp_done);
        check_eq({tag, "_cfg_err"},  cfg_err,  exp_err);
        check_eq({tag, "_cfg_idx"},  cfg_idx,  exp_idx);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_queue_left"}, exp_q.size(), 0);
        if (exp_done) check_eq({tag, "_done_gap"}, done_cyc - last_end_cyc, GAP);
    endtask

    // Called at edge+1; pulses cfg_restart for one cycle and checks the flags.
    task automatic pulse_restart(input string tag);
        #1 cfg_restart = 1'b1;
        @(posedge sys_clk);
        #1;
        check_eq({tag, "_flags"}, {cfg_done, cfg_err, busy}, 3'b001);
        check_eq({tag, "_idx"},   cfg_idx, 0);
        #1 cfg_restart = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        for (int i = 0; i < 500 && n_acc < target; i++) begin
            @(posedge sys_clk);
            #1;
        end
        check_eq("accept_seen", n_acc >= target, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int p0;
        sys_rst_n   = 1'b0;
        cfg_restart = 1'b0;
        tbl[0] = 24'h300882;
        tbl[1] = 24'h310303;
        tbl[2] = 24'h430061;
        repeat (3) @(posedge sys_clk);
        #2;
        check_reset("por");
        check_eq("wr_en",    wr_en,    1);
        check_eq("rd_en",    rd_en,    0);
        check_eq("addr_num", addr_num, 1);

        // T1/T2: power-up run through the fixed table
        ref_build(-1, -1);
        sys_rst_n = 1'b1;
        measure_start("pwr_latency", PWR + 1);
        wait_finish();
        check_outcome("t1");

        // T5: restart from DONE, then a restart pulse during BUSY is ignored
        randomize_table();
        ref_build(-1, -1);
        pulse_restart("t5_restart");
        measure_start("restart_latency", 1);
        wait_acc(n_acc + 1);
        #1 cfg_restart = 1'b1;
        @(posedge sys_clk);
        #1 cfg_restart = 1'b0;
        check_eq("t5_busy_restart_ignored", {busy, cfg_idx}, {1'b1, 8'd0});
        wait_finish();
        check_outcome("t5");

        // T3: entry 1 hangs once, is recovered and reissued
        randomize_table();
        ref_build(1, -1);
        p0 = n_pulse;
        pulse_restart("t3_restart");
        wait_finish();
        check_outcome("t3");
        check_eq("t3_pulses", n_pulse - p0, 1);

        // T4: entry 2 always hangs -> error after the retry
        randomize_table();
        ref_build(-1, 2);
        p0 = n_pulse;
        pulse_restart("t4_restart");
        wait_finish();
        check_outcome("t4");
        check_eq("t4_pulses", n_pulse - p0, RETRIES);

        // T6: restart from ERR, then async reset during BUSY of entry 1
        randomize_table();
        ref_build(-1, -1);
        p0 = n_acc;
        pulse_restart("t6_restart");
        wait_acc(p0 + 2);
        #1 sys_rst_n = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        ref_build(-1, -1);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        measure_start("rst_pwr_latency", PWR + 1);
        wait_finish();
        check_outcome("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
